// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: handshake bundle for one elastic pipeline stage.
// Carries the upstream (In_*) and downstream (Out_*) valid/ready channels
// that surround a pipe_stage_reg instance.
//   slave  : the stage register itself.
//   master : the surrounding environment (upstream producer + downstream consumer).
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4
);

  logic              In_valid;
  logic              In_ready;
  logic [DATA_W-1:0] In_data;
  logic [CTRL_W-1:0] In_ctrl;

  logic              Out_valid;
  logic              Out_ready;
  logic [DATA_W-1:0] Out_data;
  logic [CTRL_W-1:0] Out_ctrl;

  modport slave (
    input  In_valid,
    input  In_data,
    input  In_ctrl,
    output In_ready,
    output Out_valid,
    output Out_data,
    output Out_ctrl,
    input  Out_ready
  );

  modport master (
    output In_valid,
    output In_data,
    output In_ctrl,
    input  In_ready,
    input  Out_valid,
    input  Out_data,
    input  Out_ctrl,
    output Out_ready
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline stage register with a two-entry skid buffer.
// Holds a payload plus control bits under a valid/ready handshake, sustaining
// one transfer per cycle while downstream is ready and absorbing up to two
// entries when it is not. Flush squashes everything held; control bits are
// zero whenever no valid instruction is presented downstream.
// All outputs come straight from flops: no combinational path from Out_ready
// to In_ready or from In_* to Out_*.
// Optional feature macro: PIPE_STAGE_PERF_EN adds the CNT_W parameter and the
// saturating back-pressure counter on Stall_cnt.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic                  Clk,
  input  logic                  Clrn,
  input  logic                  Flush,
  pipe_stage_reg_if.slave       bus,
  output logic [1:0]            Occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]      Stall_cnt
`endif
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  logic in_fire;
  logic out_fire;

  // Handshake events, built only from registered ready/valid and raw inputs.
  always_comb begin
    in_fire  = bus.In_valid & in_ready_q;
    out_fire = out_valid_q & bus.Out_ready;
  end

  // Next-state and datapath load selection for the head/skid pair.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (Flush) begin
      // Any out_fire this cycle has already completed downstream; the
      // presented input is simply not captured.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            head_data_d = bus.In_data;
            head_ctrl_d = bus.In_ctrl;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head_data_d = bus.In_data;
            head_ctrl_d = bus.In_ctrl;
          end else if (in_fire) begin
            state_d     = TWO;
            skid_data_d = bus.In_data;
            skid_ctrl_d = bus.In_ctrl;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // In_ready is low here, so only a dequeue can happen.
          if (out_fire) begin
            state_d     = ONE;
            head_data_d = skid_data_q;
            head_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    // Head control bits are the Out_ctrl flop: zero them whenever the stage
    // will present a bubble so Out_ctrl needs no output-side masking gate.
    // Payload data is left untouched on flush and dequeue.
    if (state_d == EMPTY) begin
      head_ctrl_d = '0;
    end

    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  // Stage state, handshake flags and payload storage.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign bus.In_ready  = in_ready_q;
  assign bus.Out_valid = out_valid_q;
  assign bus.Out_data  = head_data_q;
  assign bus.Out_ctrl  = head_ctrl_q;
  assign Occupancy     = state_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where a valid head is blocked by downstream; saturate.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !bus.Out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Back-pressure counter; only reset clears it, Flush does not.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + scoreboard bench for pipe_stage_reg. Inputs change on the
// falling edge; outputs are checked on the falling edge against a queue of
// expected head entries.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned EW = DW + CW;
  localparam int unsigned SW = 4;
  localparam int unsigned STALL_MAX = (1 << SW) - 1;

  logic       Clk = 1'b0;
  logic       Clrn;
  logic       Flush;
  logic [1:0] Occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [SW-1:0] Stall_cnt;
`endif

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_reg #(
    .DATA_W(DW),
    .CTRL_W(CW)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .CNT_W (SW)
`endif
  ) dut (
    .Clk      (Clk),
    .Clrn     (Clrn),
    .Flush    (Flush),
    .bus      (bus),
    .Occupancy(Occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .Stall_cnt(Stall_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  int unsigned   checks   = 0;
  int unsigned   failures = 0;
  logic [EW-1:0] sb_q[$];
  int unsigned   n_out    = 0;
  int unsigned   stall_m  = 0;
  logic          last_accept;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    bus.In_valid  = v;
    bus.In_data   = d;
    bus.In_ctrl   = c;
    bus.Out_ready = ordy;
    Flush         = fl;
  endtask

  // Check outputs against the model, advance the model by one clock edge.
  task automatic step();
    int unsigned   occ = sb_q.size();
    logic          in_f;
    logic          out_f;
    logic [EW-1:0] head;
    check("in_ready", 64'(bus.In_ready), 64'(occ != 2));
    check("occupancy", 64'(Occupancy), 64'(occ));
    check("out_valid", 64'(bus.Out_valid), 64'(occ != 0));
    if (occ != 0) begin
      head = sb_q[0];
      check("out_data", 64'(bus.Out_data), 64'(head[EW-1:CW]));
      check("out_ctrl", 64'(bus.Out_ctrl), 64'(head[CW-1:0]));
    end else begin
      check("out_ctrl_bubble", 64'(bus.Out_ctrl), 64'h0);
    end
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", 64'(Stall_cnt), 64'(stall_m));
`endif
    in_f  = bus.In_valid && (occ != 2);
    out_f = (occ != 0) && bus.Out_ready;
    if ((occ != 0) && !bus.Out_ready && (stall_m != STALL_MAX)) stall_m++;
    if (out_f) begin
      void'(sb_q.pop_front());
      n_out++;
    end
    if (Flush) sb_q.delete();
    else if (in_f) sb_q.push_back({bus.In_data, bus.In_ctrl});
    last_accept = in_f && !Flush;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic async_reset_check(input string tag);
    Clrn = 1'b0;
    #1;
    sb_q.delete();
    stall_m = 0;
    check({tag, "_out_valid"}, 64'(bus.Out_valid), 64'h0);
    check({tag, "_out_ctrl"}, 64'(bus.Out_ctrl), 64'h0);
    check({tag, "_in_ready"}, 64'(bus.In_ready), 64'h1);
    check({tag, "_occupancy"}, 64'(Occupancy), 64'h0);
`ifdef PIPE_STAGE_PERF_EN
    check({tag, "_stall_cnt"}, 64'(Stall_cnt), 64'h0);
`endif
  endtask

  initial begin
    int unsigned n0;
    // Reset with random inputs.
    Clrn = 1'b0;
    drive(1'($urandom), $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
    @(posedge Clk);
    drive(1'($urandom), $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
    @(negedge Clk);
    async_reset_check("reset");
    check("reset_out_data", 64'(bus.Out_data), 64'h0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    Clrn = 1'b1;
    step();

    // First transfer after reset.
    drive(1'b1, 32'h1000_0004, 4'b1011, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("first_data", 64'(bus.Out_data), 64'h1000_0004);
    check("first_ctrl", 64'(bus.Out_ctrl), 64'hb);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    step();

    // Streaming 0x1..0x10 at full rate.
    n0 = n_out;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, DW'(i), CW'(i * 3), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    step();
    check("stream_count", 64'(n_out - n0), 64'd16);

    // Back-pressure: A, B absorbed, C held off.
    n0 = n_out;
    drive(1'b1, 32'hA, 4'h1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hB, 4'h2, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hC, 4'h3, 1'b0, 1'b0);
    step();
    check("bp_occupancy", 64'(Occupancy), 64'h2);
    check("bp_in_ready", 64'(bus.In_ready), 64'h0);
    step();
    drive(1'b1, 32'hC, 4'h3, 1'b1, 1'b0);
    last_accept = 1'b0;
    for (int t = 0; t < 4 && !last_accept; t++) step();
    check("bp_c_accepted", 64'(last_accept), 64'h1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    step();
    step();
    check("bp_count", 64'(n_out - n0), 64'd3);

    // Flush at occupancy 2 with 0xD presented.
    drive(1'b1, 32'h11, 4'h5, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h12, 4'h6, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hD, 4'hF, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("flush_occupancy", 64'(Occupancy), 64'h0);
    check("flush_out_valid", 64'(bus.Out_valid), 64'h0);
    step();
    step();

    // Flush together with in_fire and out_fire at occupancy 1.
    n0 = n_out;
    drive(1'b1, 32'h21, 4'h9, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hE, 4'h7, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("sim_flush_occ", 64'(Occupancy), 64'h0);
    step();
    step();
    check("sim_flush_count", 64'(n_out - n0), 64'd1);

    // Random traffic with occasional flush.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), $urandom, 4'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 31) == 0));
      step();
    end

    // Asynchronous reset with two entries held.
    drive(1'b1, 32'h31, 4'h1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h32, 4'h2, 1'b0, 1'b0);
    step();
    #2;
    async_reset_check("midreset");
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge Clk);
    Clrn = 1'b1;
    step();

`ifdef PIPE_STAGE_PERF_EN
    // Stall counter saturation, then cleared by reset.
    drive(1'b1, 32'h41, 4'h3, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    check("stall_saturated", 64'(Stall_cnt), 64'd15);
    async_reset_check("perf_reset");
    @(negedge Clk);
    Clrn = 1'b1;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
